// File: rtl/lap_stopwatch.sv
// BCD stopwatch with start/stop/clear control, prescaled count ticks and a
// first-word fall-through lap FIFO for a downstream display or UART reader.
module lap_stopwatch #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic                  lap_pop,
  output logic [4*DIGITS-1:0]   bcd_count,
  output logic                  running,
  output logic                  wrapped,
  output logic [4*DIGITS-1:0]   lap_data,
  output logic                  lap_valid,
  output logic                  lap_full,
  output logic                  lap_overrun
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [PW-1:0]  r_presc;
  logic [W-1:0]   r_count;
  logic           r_running;
  logic           r_wrapped;
  logic [W-1:0]   r_mem [LAP_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_fill;
  logic [W-1:0]   r_lap_data;
  logic           r_lap_valid;
  logic           r_lap_full;
  logic           r_lap_overrun;

  logic [W-1:0]   w_count_inc;
  logic           w_at_max;
  logic           w_tick;
  logic           w_sat;
  logic           w_push;
  logic           w_pop;
  logic           w_write;
  logic [CW-1:0]  w_remain;
  logic [CW-1:0]  w_fill_next;
  logic [AW-1:0]  w_rd_next;
  logic [W-1:0]   w_head_next;

  // Ripple BCD increment; the final carry-out means every digit is 9.
  always_comb begin
    logic v_carry;
    v_carry     = 1'b1;
    w_count_inc = r_count;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v_carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = 4'(r_count[4*i +: 4] + 4'd1);
          v_carry               = 1'b0;
        end
      end
    end
    w_at_max = v_carry;
  end

  assign w_tick = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));
  assign w_sat  = w_tick && w_at_max && (WRAP == 0);

  // Command priority: clear > stop > start.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && !stop) w_next_state = S_RUN;
        S_RUN:   if (stop || w_sat)  w_next_state = S_STOP;
        S_STOP:  if (start && !stop) w_next_state = S_RUN;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; the head register is precomputed so lap_data is registered.
  always_comb begin
    w_push      = lap && !clear && (r_state != S_IDLE);
    w_pop       = lap_pop && r_lap_valid && !clear;
    w_write     = w_push && (!r_lap_full || w_pop);
    w_remain    = r_fill - CW'(w_pop);
    w_fill_next = w_remain + CW'(w_write);
    w_rd_next   = r_rd_ptr + AW'(w_pop);
    w_head_next = '0;
    if (w_fill_next != '0) begin
      if (w_remain == '0) w_head_next = r_count;
      else                w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_count       <= '0;
      r_running     <= 1'b0;
      r_wrapped     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fill        <= '0;
      r_lap_data    <= '0;
      r_lap_valid   <= 1'b0;
      r_lap_full    <= 1'b0;
      r_lap_overrun <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == S_RUN);
      r_wrapped <= 1'b0;
      if (clear) begin
        r_presc       <= '0;
        r_count       <= '0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_fill        <= '0;
        r_lap_data    <= '0;
        r_lap_valid   <= 1'b0;
        r_lap_full    <= 1'b0;
        r_lap_overrun <= 1'b0;
      end else begin
        if (r_state == S_RUN) r_presc <= w_tick ? '0 : r_presc + PW'(1);
        else if (r_state == S_IDLE) r_presc <= '0;
        if (w_tick) begin
          if (w_at_max) begin
            r_wrapped <= 1'b1;
            if (WRAP != 0) r_count <= '0;
          end else begin
            r_count <= w_count_inc;
          end
        end
        if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rd_ptr    <= w_rd_next;
        r_fill      <= w_fill_next;
        r_lap_data  <= w_head_next;
        r_lap_valid <= (w_fill_next != '0);
        r_lap_full  <= (w_fill_next == CW'(LAP_DEPTH));
        if (w_push && !w_write) r_lap_overrun <= 1'b1;
      end
    end
  end

  // Lap storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= r_count;
  end

  assign bcd_count   = r_count;
  assign running     = r_running;
  assign wrapped     = r_wrapped;
  assign lap_data    = r_lap_data;
  assign lap_valid   = r_lap_valid;
  assign lap_full    = r_lap_full;
  assign lap_overrun = r_lap_overrun;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: a wrapping instance and a saturating instance.
module tb_lap_stopwatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear, lap, lap_pop;
  logic [15:0] bcd_count, lap_data;
  logic        running, wrapped, lap_valid, lap_full, lap_overrun;

  logic        s_start, s_stop, s_clear, s_lap, s_lap_pop;
  logic [15:0] s_bcd_count, s_lap_data;
  logic        s_running, s_wrapped, s_lap_valid, s_lap_full, s_lap_overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.DIGITS(4), .TICK_DIV(2), .WRAP(1), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lap_pop(lap_pop), .bcd_count(bcd_count), .running(running), .wrapped(wrapped),
    .lap_data(lap_data), .lap_valid(lap_valid), .lap_full(lap_full),
    .lap_overrun(lap_overrun)
  );

  lap_stopwatch #(.DIGITS(4), .TICK_DIV(2), .WRAP(0), .LAP_DEPTH(4)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .clear(s_clear), .lap(s_lap),
    .lap_pop(s_lap_pop), .bcd_count(s_bcd_count), .running(s_running),
    .wrapped(s_wrapped), .lap_data(s_lap_data), .lap_valid(s_lap_valid),
    .lap_full(s_lap_full), .lap_overrun(s_lap_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {start, stop, clear, lap, lap_pop} = '0;
    {s_start, s_stop, s_clear, s_lap, s_lap_pop} = '0;
    step();
    step();
    checks++; if (bcd_count !== 16'h0000) begin failures++; $display("FAIL rst_count got=%h exp=0000", bcd_count); end
    checks++; if ({running, wrapped, lap_valid, lap_full, lap_overrun} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000", {running, wrapped, lap_valid, lap_full, lap_overrun}); end
    checks++; if (lap_data !== 16'h0000) begin failures++; $display("FAIL rst_lap_data got=%h exp=0000", lap_data); end
    checks++; if (s_bcd_count !== 16'h0000 || s_running !== 1'b0) begin
      failures++; $display("FAIL rst_sat got=%h/%b exp=0000/0", s_bcd_count, s_running); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_run_stop();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (running !== 1'b1 || bcd_count !== 16'h0000) begin
      failures++; $display("FAIL run_start got=%b/%h exp=1/0000", running, bcd_count); end
    repeat (20) step();
    checks++; if (bcd_count !== 16'h0010) begin failures++; $display("FAIL run_20clk got=%h exp=0010", bcd_count); end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (running !== 1'b0 || bcd_count !== 16'h0010) begin
      failures++; $display("FAIL stop_now got=%b/%h exp=0/0010", running, bcd_count); end
    repeat (5) step();
    checks++; if (bcd_count !== 16'h0010) begin failures++; $display("FAIL stop_frozen got=%h exp=0010", bcd_count); end
  endtask

  task automatic test_wrap();
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (bcd_count !== 16'h0000 || running !== 1'b0) begin
      failures++; $display("FAIL wrap_clear got=%h/%b exp=0000/0", bcd_count, running); end
    start = 1'b1; step(); start = 1'b0;
    repeat (19998) step();
    checks++; if (bcd_count !== 16'h9999 || wrapped !== 1'b0) begin
      failures++; $display("FAIL wrap_at_max got=%h/%b exp=9999/0", bcd_count, wrapped); end
    step(); step();
    checks++; if (bcd_count !== 16'h0000 || wrapped !== 1'b1 || running !== 1'b1) begin
      failures++; $display("FAIL wrap_event got=%h/%b/%b exp=0000/1/1", bcd_count, wrapped, running); end
    step();
    checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL wrap_pulse_len got=%b exp=0", wrapped); end
    step();
    checks++; if (bcd_count !== 16'h0001) begin failures++; $display("FAIL wrap_resume got=%h exp=0001", bcd_count); end
  endtask

  task automatic test_saturate();
    s_start = 1'b1; step(); s_start = 1'b0;
    repeat (19996) step();
    checks++; if (s_bcd_count !== 16'h9998) begin failures++; $display("FAIL sat_pre got=%h exp=9998", s_bcd_count); end
    step(); step();
    checks++; if (s_bcd_count !== 16'h9999 || s_running !== 1'b1 || s_wrapped !== 1'b0) begin
      failures++; $display("FAIL sat_max got=%h/%b/%b exp=9999/1/0", s_bcd_count, s_running, s_wrapped); end
    step(); step();
    checks++; if (s_bcd_count !== 16'h9999 || s_wrapped !== 1'b1 || s_running !== 1'b0) begin
      failures++; $display("FAIL sat_event got=%h/%b/%b exp=9999/1/0", s_bcd_count, s_wrapped, s_running); end
    step();
    checks++; if (s_wrapped !== 1'b0 || s_running !== 1'b0) begin
      failures++; $display("FAIL sat_after got=%b/%b exp=0/0", s_wrapped, s_running); end
    s_start = 1'b1; step(); s_start = 1'b0;
    checks++; if (s_running !== 1'b1 || s_bcd_count !== 16'h9999) begin
      failures++; $display("FAIL sat_restart got=%b/%h exp=1/9999", s_running, s_bcd_count); end
    step(); step();
    checks++; if (s_bcd_count !== 16'h9999 || s_running !== 1'b0) begin
      failures++; $display("FAIL sat_hold got=%h/%b exp=9999/0", s_bcd_count, s_running); end
  endtask

  task automatic test_laps();
    logic [15:0] exp_laps [4];
    exp_laps = '{16'h0003, 16'h0005, 16'h0007, 16'h0009};
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    for (int k = 0; k < 5; k++) begin
      lap = 1'b1; step(); lap = 1'b0;
      if (k == 0) begin
        checks++; if (lap_valid !== 1'b1 || lap_data !== 16'h0003) begin
          failures++; $display("FAIL lap_fwft got=%b/%h exp=1/0003", lap_valid, lap_data); end
      end
      if (k == 3) begin
        checks++; if (lap_full !== 1'b1 || lap_overrun !== 1'b0) begin
          failures++; $display("FAIL lap_full4 got=%b/%b exp=1/0", lap_full, lap_overrun); end
      end
      if (k < 4) repeat (3) step();
    end
    checks++; if (lap_full !== 1'b1 || lap_overrun !== 1'b1) begin
      failures++; $display("FAIL lap_overrun got=%b/%b exp=1/1", lap_full, lap_overrun); end
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (lap_valid !== 1'b1 || lap_data !== exp_laps[i]) begin
        failures++; $display("FAIL lap_pop%0d got=%b/%h exp=1/%h", i, lap_valid, lap_data, exp_laps[i]); end
      lap_pop = 1'b1; step(); lap_pop = 1'b0;
    end
    checks++; if (lap_valid !== 1'b0 || lap_full !== 1'b0 || lap_overrun !== 1'b1) begin
      failures++; $display("FAIL lap_drained got=%b/%b/%b exp=0/0/1", lap_valid, lap_full, lap_overrun); end
    lap_pop = 1'b1; step(); lap_pop = 1'b0;
    checks++; if (lap_valid !== 1'b0) begin failures++; $display("FAIL lap_pop_empty got=%b exp=0", lap_valid); end
    lap = 1'b1; step(); lap = 1'b0;
    checks++; if (lap_valid !== 1'b1 || lap_data !== 16'h0012) begin
      failures++; $display("FAIL lap_in_stop got=%b/%h exp=1/0012", lap_valid, lap_data); end
  endtask

  task automatic test_push_pop_full();
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    lap = 1'b1; repeat (4) step(); lap = 1'b0;
    checks++; if (lap_full !== 1'b1 || lap_overrun !== 1'b0) begin
      failures++; $display("FAIL ppf_fill got=%b/%b exp=1/0", lap_full, lap_overrun); end
    lap = 1'b1; lap_pop = 1'b1; step(); lap = 1'b0; lap_pop = 1'b0;
    checks++; if (lap_full !== 1'b1 || lap_overrun !== 1'b0 || lap_valid !== 1'b1) begin
      failures++; $display("FAIL ppf_both got=%b/%b/%b exp=1/0/1", lap_full, lap_overrun, lap_valid); end
  endtask

  task automatic test_cmd_priority();
    start = 1'b1; step(); start = 1'b0;
    step();
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_over_start got=%b exp=0", running); end
    lap = 1'b1; step(); lap = 1'b0;
    checks++; if (lap_overrun !== 1'b1) begin failures++; $display("FAIL prio_overrun got=%b exp=1", lap_overrun); end
    clear = 1'b1; lap = 1'b1; step(); clear = 1'b0; lap = 1'b0;
    checks++; if (running !== 1'b0 || bcd_count !== 16'h0000 || lap_valid !== 1'b0 ||
                  lap_full !== 1'b0 || lap_overrun !== 1'b0) begin
      failures++; $display("FAIL clear_lap got=%b/%h/%b/%b/%b exp=0/0000/0/0/0",
                           running, bcd_count, lap_valid, lap_full, lap_overrun); end
    lap = 1'b1; step(); lap = 1'b0;
    checks++; if (lap_valid !== 1'b0) begin failures++; $display("FAIL lap_idle got=%b exp=0", lap_valid); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    lap = 1'b1; step(); lap = 1'b0;
    repeat (2) step();
    lap = 1'b1; step(); lap = 1'b0;
    checks++; if (lap_valid !== 1'b1 || lap_data !== 16'h0003 || running !== 1'b1) begin
      failures++; $display("FAIL ar_pre got=%b/%h/%b exp=1/0003/1", lap_valid, lap_data, running); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bcd_count !== 16'h0000 || {running, wrapped, lap_valid, lap_full, lap_overrun} !== 5'b0 ||
                  lap_data !== 16'h0000) begin
      failures++; $display("FAIL ar_immediate got=%h/%b/%h exp=0000/00000/0000", bcd_count,
                           {running, wrapped, lap_valid, lap_full, lap_overrun}, lap_data); end
    step();
    start = 1'b1; rst = 1'b1;
    step(); start = 1'b0;
    checks++; if (running !== 1'b1 || bcd_count !== 16'h0000) begin
      failures++; $display("FAIL ar_restart got=%b/%h exp=1/0000", running, bcd_count); end
    repeat (4) step();
    checks++; if (bcd_count !== 16'h0002 || lap_valid !== 1'b0) begin
      failures++; $display("FAIL ar_resume got=%h/%b exp=0002/0", bcd_count, lap_valid); end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_wrap();
    test_saturate();
    test_laps();
    test_push_pop_full();
    test_cmd_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
